axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 202 ++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-lite single-outstanding master: turns one command into an AW/W/B or AR/R
// exchange and reports the response with a saturating accept-to-handshake latency.
module axi_lite_master #(
  parameter int C_LAT_BITS = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [31:0]           cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_wr,
  output logic [C_LAT_BITS-1:0] rsp_cycles,
  output logic [31:0]           m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [C_LAT_BITS-1:0] lat_q, lat_d, lat_inc;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic [C_LAT_BITS-1:0] rsp_cycles_q, rsp_cycles_d;

  // Latency counter sticks at all-ones instead of wrapping.
  assign lat_inc = (&lat_q) ? lat_q : lat_q + {{(C_LAT_BITS-1){1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    lat_d        = lat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_cycles_d = rsp_cycles_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_wr_d    = cmd_wr;
          lat_d       = '0;
          cmd_ready_d = 1'b0;
          if (cmd_wr) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        lat_d = lat_inc;
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        lat_d = lat_inc;
        if (m_axi_bvalid) begin
          state_d      = RESP;
          bready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_resp_d   = m_axi_bresp;
          rsp_rdata_d  = '0;
          rsp_cycles_d = lat_inc;
        end
      end
      READ: begin
        lat_d = lat_inc;
        if (m_axi_arready) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        lat_d = lat_inc;
        if (m_axi_rvalid) begin
          state_d      = RESP;
          rready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_resp_d   = m_axi_rresp;
          rsp_rdata_d  = m_axi_rdata;
          rsp_cycles_d = lat_inc;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // Reset drops any transaction in flight; the slave shares this reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      lat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= '0;
      rsp_wr_q     <= 1'b0;
      rsp_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      lat_q        <= lat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_wr        = rsp_wr_q;
  assign rsp_cycles    = rsp_cycles_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a wait-state programmable AXI-lite slave plus a
// scoreboard of expected responses built from each command and its wait profile.
module tb_axi_lite_master;

  localparam int LB = 4;

  logic          aclk, aresetn;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [31:0]   cmd_addr, cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_wr;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [LB-1:0] rsp_cycles;
  logic [31:0]   m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  axi_lite_master #(.C_LAT_BITS(LB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_wr(rsp_wr), .rsp_cycles(rsp_cycles),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    int          cycles, lat, aw_hi, w_hi, ar_hi;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int compare_count = 0;
  int mismatch_count = 0;
  int rsp_count = 0;

  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, b_pend, r_pend;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: each ready/valid appears once its programmed wait count has elapsed.
  always_comb begin
    m_axi_awready = m_axi_awvalid && !aw_got && (aw_cnt >= aw_wait);
    m_axi_wready  = m_axi_wvalid && !w_got && (w_cnt >= w_wait);
    m_axi_bvalid  = b_pend && (b_cnt >= b_wait);
    m_axi_arready = m_axi_arvalid && !r_pend && (ar_cnt >= ar_wait);
    m_axi_rvalid  = r_pend && (r_cnt >= r_wait);
    m_axi_bresp   = cfg_bresp;
    m_axi_rresp   = cfg_rresp;
    m_axi_rdata   = cfg_rdata;
  end

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (m_axi_awvalid && !m_axi_awready && !aw_got) aw_cnt <= aw_cnt + 1;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_got <= 1'b1; aw_cnt <= 0; cap_awaddr <= m_axi_awaddr;
      end
      if (m_axi_wvalid && !m_axi_wready && !w_got) w_cnt <= w_cnt + 1;
      if (m_axi_wvalid && m_axi_wready) begin
        w_got <= 1'b1; w_cnt <= 0; cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb;
      end
      if ((aw_got || (m_axi_awvalid && m_axi_awready)) &&
          (w_got || (m_axi_wvalid && m_axi_wready))) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
      end
      if (b_pend) begin
        if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
        else if (!m_axi_bvalid) b_cnt <= b_cnt + 1;
      end
      if (m_axi_arvalid && !m_axi_arready && !r_pend) ar_cnt <= ar_cnt + 1;
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0; cap_araddr <= m_axi_araddr;
      end
      if (r_pend) begin
        if (m_axi_rvalid && m_axi_rready) r_pend <= 1'b0;
        else if (!m_axi_rvalid) r_cnt <= r_cnt + 1;
      end
    end
  end

  // Monitor on the falling edge: tracks accept time and valid durations, pops the scoreboard.
  int cyc = 0, accept_cyc = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;
  logic prev_rsp = 1'b0;
  always @(negedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (cmd_valid && cmd_ready) begin
        accept_cyc = cyc; aw_hi = 0; w_hi = 0; ar_hi = 0;
      end
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid)  w_hi++;
      if (m_axi_arvalid) ar_hi++;
      if (rsp_valid) begin
        checkOutput("pulse_once", {63'd0, prev_rsp}, 64'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          last_exp = sb.pop_front();
          rsp_count++;
          checkOutput("rsp_wr", {63'd0, rsp_wr}, {63'd0, last_exp.wr});
          checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, last_exp.rdata});
          checkOutput("rsp_resp", {62'd0, rsp_resp}, {62'd0, last_exp.resp});
          checkOutput("rsp_cycles", {60'd0, rsp_cycles}, 64'(last_exp.cycles));
          checkOutput("rsp_latency", 64'(cyc - accept_cyc), 64'(last_exp.lat));
          if (last_exp.wr) begin
            checkOutput("awaddr", {32'd0, cap_awaddr}, {32'd0, last_exp.addr});
            checkOutput("wdata", {32'd0, cap_wdata}, {32'd0, last_exp.wdata});
            checkOutput("wstrb", {60'd0, cap_wstrb}, {60'd0, last_exp.wstrb});
            checkOutput("awvalid_cycles", 64'(aw_hi), 64'(last_exp.aw_hi));
            checkOutput("wvalid_cycles", 64'(w_hi), 64'(last_exp.w_hi));
          end else begin
            checkOutput("araddr", {32'd0, cap_araddr}, {32'd0, last_exp.addr});
            checkOutput("arvalid_cycles", 64'(ar_hi), 64'(last_exp.ar_hi));
          end
        end
      end else if (prev_rsp) begin
        checkOutput("hold_resp", {62'd0, rsp_resp}, {62'd0, last_exp.resp});
        checkOutput("hold_rdata", {32'd0, rsp_rdata}, {32'd0, last_exp.rdata});
        checkOutput("idle_after_rsp", {63'd0, cmd_ready}, 64'd1);
      end
    end
    prev_rsp = rsp_valid;
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int a_w, input int d_w, input int rs_w,
                               input logic [1:0] resp, input logic [31:0] rdata);
    exp_t e;
    int raw, target, k;
    aw_wait = a_w; w_wait = d_w; b_wait = rs_w; ar_wait = a_w; r_wait = rs_w;
    cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rdata;
    k = 0;
    do begin
      @(posedge aclk); #1; k++;
    end while (!cmd_ready && k < 100);
    checkOutput("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    raw = wr ? 2 + ((a_w > d_w) ? a_w : d_w) + rs_w : 2 + a_w + rs_w;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.wstrb = strb;
    e.rdata = wr ? 32'd0 : rdata; e.resp = resp;
    e.cycles = (raw > (1 << LB) - 1) ? (1 << LB) - 1 : raw;
    e.lat = raw + 1; e.aw_hi = 1 + a_w; e.w_hi = 1 + d_w; e.ar_hi = 1 + a_w;
    sb.push_back(e);
    target = rsp_count + 1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    @(posedge aclk); #1;
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_wstrb = ~strb;
    k = 0;
    while (rsp_count < target && k < 200) begin
      @(negedge aclk); k++;
    end
    checkOutput("rsp_arrived", 64'(rsp_count), 64'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("reset_valids", {58'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                m_axi_bready, m_axi_rready, rsp_valid}, 64'd0);
    checkOutput("reset_rsp_fields", {25'd0, rsp_rdata, rsp_resp, rsp_wr, rsp_cycles}, 64'd0);

    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0032, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0,         4'h0, 3, 0, 0, 2'b00, 32'h0000_0032);
    applyStimulus(1'b1, 32'h0000_1004, 32'hA5A5_0F0F, 4'h3, 2, 0, 1, 2'b00, 32'h0);
    applyStimulus(1'b1, 32'h0000_2008, 32'h1234_5678, 4'hC, 0, 2, 0, 2'b00, 32'h0);
    applyStimulus(1'b1, 32'hDEAD_0010, 32'hCAFE_F00D, 4'h5, 1, 1, 0, 2'b10, 32'h0);
    applyStimulus(1'b0, 32'h8000_0020, 32'h0,         4'h0, 1, 2, 2, 2'b11, 32'h55AA_33CC);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 40, 2'b00, 32'hFFFF_0001);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0,         4'h0, 0, 0, 0, 2'b01, 32'h0BAD_BEEF);

    // Reset while the read data phase is pending: nothing is pushed, so any pulse is flagged.
    ar_wait = 0; r_wait = 30; cfg_rdata = 32'h1111_2222;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_0080;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!m_axi_rready && k < 20) begin
      @(posedge aclk); #1; k++;
    end
    checkOutput("reached_rdata", {63'd0, m_axi_rready}, 64'd1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    checkOutput("midreset_valids", {58'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                m_axi_bready, m_axi_rready, rsp_valid}, 64'd0);
    checkOutput("midreset_rsp_fields", {25'd0, rsp_rdata, rsp_resp, rsp_wr, rsp_cycles}, 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1; r_wait = 0;
    @(negedge aclk);
    checkOutput("midreset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (5) @(negedge aclk);
    checkOutput("midreset_no_rsp", 64'(rsp_count), 64'd8);

    applyStimulus(1'b1, 32'h0000_00F0, 32'h7777_8888, 4'h9, 0, 1, 2, 2'b00, 32'h0);
    repeat (4) @(negedge aclk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
